// File: rtl/addr1_queue_ctrl.sv
// Ordered FIFO controller over an external addr1_0_ext 1R1W SRAM macro.
// A 2-entry prefetch buffer absorbs the macro's one-cycle read latency.
module addr1_queue_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic [3:0]       io_count,
    output logic             mem_W0_en,
    output logic [AW-1:0]    mem_W0_addr,
    output logic [WIDTH-1:0] mem_W0_data,
    output logic             mem_R0_en,
    output logic [AW-1:0]    mem_R0_addr,
    input  logic [WIDTH-1:0] mem_R0_data
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      ram_count_r;
    logic             rd_inflight_r;
    logic [WIDTH-1:0] pf_mem_r [2];
    logic             pf_head_r;
    logic [1:0]       pf_count_r;

    logic             enq_fire_s;
    logic             deq_fire_s;
    logic             bypass_s;
    logic             ram_wr_s;
    logic             rd_issue_s;
    logic             pf_push_s;
    logic             pf_tail_s;
    logic [WIDTH-1:0] pf_push_data_s;
    logic [2:0]       credit_s;

    // Handshakes, bypass/RAM steering, read-credit and all port outputs.
    always_comb begin
        io_enq_ready   = 1'b0;
        io_deq_valid   = 1'b0;
        io_count       = 4'd0;
        enq_fire_s     = 1'b0;
        deq_fire_s     = 1'b0;
        bypass_s       = 1'b0;
        ram_wr_s       = 1'b0;
        rd_issue_s     = 1'b0;
        credit_s       = {1'b0, pf_count_r} + {2'b00, rd_inflight_r};
        pf_tail_s      = pf_head_r ^ pf_count_r[0];
        io_deq_bits    = pf_mem_r[pf_head_r];
        if (reset) begin
            io_enq_ready = 1'b0;
        end else begin
            io_enq_ready = (ram_count_r < DEPTH_C);
            io_deq_valid = (pf_count_r != 2'd0);
            io_count     = 4'(ram_count_r) + 4'(rd_inflight_r) + 4'(pf_count_r);
            enq_fire_s   = io_enq_valid & io_enq_ready;
            deq_fire_s   = io_deq_valid & io_deq_ready;
            // Bypass only when nothing older sits in RAM or in flight.
            bypass_s     = enq_fire_s & (ram_count_r == '0) & ~rd_inflight_r & (pf_count_r < 2'd2);
            ram_wr_s     = enq_fire_s & ~bypass_s;
            credit_s     = credit_s - {2'b00, deq_fire_s};
            rd_issue_s   = (ram_count_r != '0) & (credit_s < 3'd2);
        end
        pf_push_s      = bypass_s | rd_inflight_r;
        if (rd_inflight_r) begin
            pf_push_data_s = mem_R0_data;
        end else begin
            pf_push_data_s = io_enq_bits;
        end
        mem_W0_en      = ram_wr_s;
        mem_W0_addr    = wr_ptr_r;
        mem_W0_data    = io_enq_bits;
        mem_R0_en      = rd_issue_s;
        mem_R0_addr    = rd_ptr_r;
    end

    // Pointers, occupancy counters and prefetch buffer storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            ram_count_r   <= '0;
            rd_inflight_r <= 1'b0;
            pf_mem_r[0]   <= '0;
            pf_mem_r[1]   <= '0;
            pf_head_r     <= 1'b0;
            pf_count_r    <= 2'd0;
        end else begin
            if (ram_wr_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({ram_wr_s, rd_issue_s})
                2'b10:   ram_count_r <= ram_count_r + 1'b1;
                2'b01:   ram_count_r <= ram_count_r - 1'b1;
                default: ram_count_r <= ram_count_r;
            endcase
            rd_inflight_r <= rd_issue_s;
            // The credit rule leaves at most one entry here whenever a push lands.
            if (pf_push_s) begin
                pf_mem_r[pf_tail_s] <= pf_push_data_s;
            end
            if (deq_fire_s) begin
                pf_head_r <= ~pf_head_r;
            end
            case ({pf_push_s, deq_fire_s})
                2'b10:   pf_count_r <= pf_count_r + 2'd1;
                2'b01:   pf_count_r <= pf_count_r - 2'd1;
                default: pf_count_r <= pf_count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_addr1_queue_ctrl.sv
// Bench for addr1_queue_ctrl: SRAM model, per-cycle queue-model checker and
// directed scenarios with hand-computed expectations.
module tb_addr1_queue_ctrl;
    localparam int DEPTH = 8;
    localparam int WIDTH = 11;
    localparam int AW    = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_enq_valid = 1'b0;
    logic             io_enq_ready;
    logic [WIDTH-1:0] io_enq_bits = '0;
    logic             io_deq_valid;
    logic             io_deq_ready = 1'b0;
    logic [WIDTH-1:0] io_deq_bits;
    logic [3:0]       io_count;
    logic             mem_W0_en;
    logic [AW-1:0]    mem_W0_addr;
    logic [WIDTH-1:0] mem_W0_data;
    logic             mem_R0_en;
    logic [AW-1:0]    mem_R0_addr;
    logic [WIDTH-1:0] mem_R0_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    addr1_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready), .io_enq_bits(io_enq_bits),
        .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready), .io_deq_bits(io_deq_bits),
        .io_count(io_count),
        .mem_W0_en(mem_W0_en), .mem_W0_addr(mem_W0_addr), .mem_W0_data(mem_W0_data),
        .mem_R0_en(mem_R0_en), .mem_R0_addr(mem_R0_addr), .mem_R0_data(mem_R0_data)
    );

    always #5 clock = ~clock;

    // External SRAM macro: registered read data, valid the cycle after R0_en.
    logic [WIDTH-1:0] sram [DEPTH];
    always @(posedge clock) begin
        if (mem_W0_en) sram[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) mem_R0_data <= sram[mem_R0_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: contents, enqueue cycle, and whether the entry went through RAM.
    logic [WIDTH-1:0] mq_data[$];
    int               mq_time[$];
    bit               mq_ram[$];
    int               cyc = 0;
    int               wr_cnt = 0;
    int               rd_cnt = 0;
    int               ram_deqd = 0;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check("rst_deq_valid", int'(io_deq_valid), 0);
                check("rst_enq_ready", int'(io_enq_ready), 0);
                check("rst_count", int'(io_count), 0);
                check("rst_w0_en", int'(mem_W0_en), 0);
                check("rst_r0_en", int'(mem_R0_en), 0);
                mq_data.delete(); mq_time.delete(); mq_ram.delete();
                wr_cnt = 0; rd_cnt = 0; ram_deqd = 0;
            end else begin
                automatic logic ef = io_enq_valid & io_enq_ready;
                automatic logic df = io_deq_valid & io_deq_ready;
                automatic int   sz = mq_data.size();
                check("m_count", int'(io_count), sz);
                if (sz == 0) check("m_empty_valid", int'(io_deq_valid), 0);
                if (io_deq_valid && sz > 0) check("m_deq_bits", int'(io_deq_bits), int'(mq_data[0]));
                if (sz > 0 && (cyc - mq_time[0]) >= 3) check("m_head_visible", int'(io_deq_valid), 1);
                if (sz < DEPTH) check("m_enq_ready_lo", int'(io_enq_ready), 1);
                if (sz >= DEPTH + 2) check("m_enq_ready_full", int'(io_enq_ready), 0);
                check("m_reads_out_le2", int'((rd_cnt - ram_deqd) <= 2 && rd_cnt >= ram_deqd), 1);
                if (mem_W0_en) begin
                    check("m_w0_needs_enq", int'(ef), 1);
                    check("m_w0_addr", int'(mem_W0_addr), wr_cnt % DEPTH);
                    check("m_w0_data", int'(mem_W0_data), int'(io_enq_bits));
                end
                if (mem_R0_en) begin
                    check("m_r0_addr", int'(mem_R0_addr), rd_cnt % DEPTH);
                    check("m_r0_written", int'(rd_cnt < wr_cnt), 1);
                end
                if (df && sz > 0) begin
                    if (mq_ram[0]) ram_deqd++;
                    void'(mq_data.pop_front()); void'(mq_time.pop_front()); void'(mq_ram.pop_front());
                end
                if (ef) begin
                    mq_data.push_back(io_enq_bits); mq_time.push_back(cyc); mq_ram.push_back(mem_W0_en);
                end
                wr_cnt += int'(mem_W0_en);
                rd_cnt += int'(mem_R0_en);
            end
            cyc++;
        end
    end

    task automatic step(input logic rst, input logic ev, input logic [WIDTH-1:0] eb, input logic dr);
        @(posedge clock); #1;
        reset = rst; io_enq_valid = ev; io_enq_bits = eb; io_deq_ready = dr;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, budget;
        logic [WIDTH-1:0] v;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);

        // Single entry through the bypass path.
        step(1'b0, 1'b1, 11'h5A5, 1'b1);
        check("se_enq_ready", int'(io_enq_ready), 1);
        check("se_w0_c0", int'(mem_W0_en), 0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("se_valid_c1", int'(io_deq_valid), 1);
        check("se_bits_c1", int'(io_deq_bits), 'h5A5);
        check("se_w0_c1", int'(mem_W0_en), 0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("se_count_c2", int'(io_count), 0);
        check("se_valid_c2", int'(io_deq_valid), 0);

        // Fill to capacity with the consumer stalled.
        for (int i = 0; i < 10; i++) begin
            v = 11'(i);
            step(1'b0, 1'b1, v, 1'b0);
            check("fill_enq_ready", int'(io_enq_ready), 1);
            check("fill_w0_en", int'(mem_W0_en), (i >= 2) ? 1 : 0);
            if (i >= 2) check("fill_w0_addr", int'(mem_W0_addr), i - 2);
            check("fill_r0_en", int'(mem_R0_en), 0);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        check("fill_enq_ready_full", int'(io_enq_ready), 0);
        check("fill_count", int'(io_count), 10);
        check("fill_r0_idle", int'(mem_R0_en), 0);

        // Drain: ten values on ten consecutive cycles.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            check("drain_valid", int'(io_deq_valid), 1);
            check("drain_bits", int'(io_deq_bits), k);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        check("drain_enq_ready", int'(io_enq_ready), 1);
        check("drain_count", int'(io_count), 0);

        // Streaming with three entries preloaded; write pointer wraps.
        for (int i = 0; i < 3; i++) begin
            v = 11'('h0A0 + i);
            step(1'b0, 1'b1, v, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            v = 11'('h100 + i);
            step(1'b0, 1'b1, v, 1'b1);
            check("strm_valid", int'(io_deq_valid), 1);
            check("strm_bits", int'(io_deq_bits), (i < 3) ? ('h0A0 + i) : ('h100 + i - 3));
            check("strm_count", int'(io_count), 3);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            check("strm_tail_bits", int'(io_deq_bits), 'h111 + i);
        end

        // Back-pressure: random consumer, independent in-order scoreboard.
        sent = 0; recv = 0; budget = 0;
        while ((sent < 200 || recv < 200) && budget < 2000) begin
            v = 11'('h200 + sent);
            step(1'b0, sent < 200, v, 1'($urandom_range(0, 1)));
            if (io_enq_valid && io_enq_ready) sent++;
            if (io_deq_valid && io_deq_ready) begin
                check("bp_order", int'(io_deq_bits), 'h200 + recv);
                recv++;
            end
            budget++;
        end
        check("bp_all_received", recv, 200);

        // Reset while five entries are held and a read is in flight.
        for (int i = 0; i < 6; i++) begin
            v = 11'('h300 + i);
            step(1'b0, 1'b1, v, 1'b0);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        check("mr_read_issued", int'(mem_R0_en), 1);
        step(1'b1, 1'b0, '0, 1'b0);
        check("mr_rst_count", int'(io_count), 0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("mr_valid", int'(io_deq_valid), 0);
        check("mr_count", int'(io_count), 0);
        check("mr_enq_ready", int'(io_enq_ready), 1);
        step(1'b0, 1'b0, '0, 1'b0);
        check("mr_no_push", int'(io_deq_valid), 0);
        check("mr_count2", int'(io_count), 0);

        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/addr1_queue_ctrl.md
# addr1_queue_ctrl

Ordered FIFO controller that wraps an external 8-entry × 11-bit one-read/one-write SRAM macro of the `addr1_0_ext` type. It accepts address entries on a ready/valid enqueue port and returns them in order on a ready/valid dequeue port. The SRAM ports `W0_*` and `R0_*` are driven from this block. A 2-entry prefetch buffer hides the macro's one-cycle read latency, so the dequeue port streams one entry per cycle. It sits directly upstream of the SRAM macro and produces all of the macro's inputs.

## Interface
- DEPTH, 8, number of SRAM entries; power of two.
- WIDTH, 11, entry width in bits.
- AW, 3, SRAM address width, log2(DEPTH).
- clock  in  1  sole clock; the SRAM macro's W0_clk and R0_clk are tied to this clock.
- reset  in  1  synchronous, active-high reset.
- io_enq_valid  in  1  producer has an entry.
- io_enq_ready  out  1  entry can be accepted this cycle.
- io_enq_bits  in  WIDTH  entry data.
- io_deq_valid  out  1  head entry available.
- io_deq_ready  in  1  consumer takes the head entry.
- io_deq_bits  out  WIDTH  head entry data.
- io_count  out  4  total entries held: RAM + in-flight read + prefetch; range 0..DEPTH+2.
- mem_W0_en, mem_W0_addr[AW], mem_W0_data[WIDTH]  out  SRAM write port.
- mem_R0_en, mem_R0_addr[AW]  out  SRAM read request.
- mem_R0_data  in  WIDTH  SRAM read data; valid the cycle after mem_R0_en=1.

## Operation
- **State:**
  - wr_ptr, rd_ptr (AW bits); ram_count (0..DEPTH).
  - rd_inflight (1 bit).
  - Prefetch buffer pf: 2-entry FIFO with pf_count 0..2.
- **Definitions:**
  - enq_fire = io_enq_valid & io_enq_ready.
  - deq_fire = io_deq_valid & io_deq_ready.
- **Enqueue ready:** io_enq_ready = !reset & (ram_count < DEPTH). It depends only on registered state; there is no combinational path from io_deq_ready.
- **Bypass:** if ram_count==0 & !rd_inflight & pf_count<2, enq_fire writes straight into pf and mem_W0_en stays 0.
- **RAM write:** otherwise enq_fire drives mem_W0_en=1, mem_W0_addr=wr_ptr, mem_W0_data=io_enq_bits. wr_ptr then increments, wrapping DEPTH-1→0.
- **Read issue:**
  - Condition: ram_count>0 & (pf_count + rd_inflight − deq_fire) < 2.
  - Action: mem_R0_en=1, mem_R0_addr=rd_ptr. rd_ptr increments with wrap, and rd_inflight is set for the next cycle.
- **Read return:** when rd_inflight=1, mem_R0_data is pushed into pf at the end of the cycle. The credit rule guarantees a free pf slot.
- **Counter update:** ram_count += (RAM write) − (read issue). The pf_count update is handled the same way, using pushes and deq_fire.
- **Output:** io_deq_valid = pf_count>0; io_deq_bits = pf head.
- **Ordering:** strict FIFO order. Bypass is legal only when nothing older exists in RAM or in flight.
- **Hazard freedom:** a read is issued only when the registered ram_count>0. The read target was therefore written at least one cycle earlier, and read and write never touch the same address in the same cycle.
- **Reset:**
  - Outputs while reset=1: io_deq_valid=0, io_enq_ready=0, io_count=0, mem_W0_en=0, mem_R0_en=0.
  - State after reset: all pointers and counts are 0 and rd_inflight=0.
  - Reset mid-operation discards every held entry; a read in flight at reset is dropped.

## Timing
- **Bypass latency:** enq_fire in cycle t gives io_deq_valid=1 in t+1.
- **RAM-path latency:**
  - Write in cycle t.
  - Read issued no earlier than t+1.
  - Data captured into pf at the end of t+2; deq_valid in t+3.
- **Throughput:** 1 enqueue and 1 dequeue per cycle, sustained, including when the RAM is non-empty.
- **Capacity:** DEPTH+2 = 10 entries. io_enq_ready falls the cycle after ram_count reaches DEPTH. It rises the cycle after the first read issue from a full RAM.
- **Simultaneous events:**
  - enq and deq in the same cycle change io_count by 0.
  - Read issue and RAM write in the same cycle change ram_count by 0.
  - Bypass and read issue are mutually exclusive, because bypass needs ram_count==0 and read issue needs ram_count>0.

## Test plan
- Single entry:
  - Stimulus: reset, then enq 0x5A5 in cycle 0 with deq_ready=1.
  - Required: deq_valid=1 with bits 0x5A5 in cycle 1; mem_W0_en never asserted; io_count returns to 0 in cycle 2.
- Fill to capacity:
  - Stimulus: deq_ready=0; enq values 0..9 on consecutive cycles.
  - Required: 0 and 1 bypass into pf; 2..9 are written to RAM addresses 0..7; io_enq_ready=0 after the 10th accept; io_count=10; no mem_R0_en.
- Drain:
  - Stimulus: continue from the fill test with deq_ready=1 continuously.
  - Required: values 0..9 appear on 10 consecutive cycles with no bubble; io_enq_ready returns to 1; final io_count=0.
- Streaming with wrap:
  - Stimulus: simultaneous enq and deq of 20 values 0x100..0x113, with 3 entries pre-loaded.
  - Required: output order exact; pointers wrap past 7; io_count stays 3 throughout.
- Back-pressure:
  - Stimulus: random deq_ready at 50% over 200 entries.
  - Required: no loss, no duplication, no reordering; never two reads in flight with pf full.
- Reset mid-operation:
  - Stimulus: 5 entries held, rd_inflight=1, reset for 1 cycle.
  - Required: next cycle deq_valid=0, io_count=0, enq_ready=1; the returning read data is not pushed into pf.
